rcs_op_sequencer: RTL and testbench

Registered front-end that feeds the four-bit ripple-carry subtractor, four_bit_RCS (S = A - B; Cout = 1 means no borrow), and collects its result.
- Accepts operand pairs over a valid/ready handshake and drives them, held stable, onto the subtractor inputs.
- Waits a programmable settle time, then captures difference and borrow into a result register with its own valid/ready handshake.
- Keeps saturating operation and borrow counters for status readout.

---
 rtl/rcs_op_sequencer.sv | 104 ++++++++++
 tb/tb_rcs_op_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rcs_op_sequencer.sv
// rcs_op_sequencer: registered operand/result sequencer around a four-bit ripple-carry subtractor
module rcs_op_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic [3:0]       rcs_a,
  output logic [3:0]       rcs_b,
  input  logic [3:0]       rcs_s,
  input  logic             rcs_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_diff,
  output logic             out_borrow,
  output logic             out_zero,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] borrow_count
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       a_q, a_d, b_q, b_d;
  logic [3:0]       diff_q, diff_d;
  logic             borrow_q, borrow_d, zero_q, zero_d;
  logic [CNT_W-1:0] op_q, op_d, brw_q, brw_d;
  logic             accept, capture, handshake;
  assign in_ready     = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept       = in_valid && in_ready;
  assign capture      = state_q == SETTLE && cnt_q == 4'd1;
  assign handshake    = state_q == DONE && out_ready;
  assign out_valid    = state_q == DONE;
  assign rcs_a        = a_q;
  assign rcs_b        = b_q;
  assign out_diff     = diff_q;
  assign out_borrow   = borrow_q;
  assign out_zero     = zero_q;
  assign op_count     = op_q;
  assign borrow_count = brw_q;
  // Next state, operand latch on accept, result capture at end of settle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE:    state_d = in_valid ? SETTLE : IDLE;
      SETTLE: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = capture ? DONE : SETTLE;
      end
      DONE:    state_d = !out_ready ? DONE : in_valid ? SETTLE : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      a_d   = in_a;
      b_d   = in_b;
      cnt_d = SETTLE_LD;
    end
    if (capture) begin
      diff_d   = rcs_s;
      borrow_d = ~rcs_cout;
      zero_d   = rcs_s == 4'd0;
    end
  end
  // Saturating status counters; clear beats a same-cycle increment
  always_comb begin
    op_d  = cnt_clr ? '0 : (handshake && !(&op_q)) ? op_q + CNT_W'(1) : op_q;
    brw_d = cnt_clr ? '0 : (handshake && borrow_q && !(&brw_q)) ? brw_q + CNT_W'(1) : brw_q;
  end
  // State and datapath registers, cleared asynchronously to abort any pending operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      op_q     <= '0;
      brw_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      op_q     <= op_d;
      brw_q    <= brw_d;
    end
  end
endmodule

// File: tb/tb_rcs_op_sequencer.sv
// tb_rcs_op_sequencer: scoreboard bench for the subtractor sequencer, settle 1/CNT_W 8 and settle 3/CNT_W 2 instances
module tb_rcs_op_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic       in_valid = 1'b0, out_ready = 1'b1, cnt_clr = 1'b0;
  logic [3:0] in_a = '0, in_b = '0;
  logic       in_ready, out_valid, out_borrow, out_zero, rcs_cout;
  logic [3:0] rcs_a, rcs_b, rcs_s, out_diff;
  logic [7:0] op_count, borrow_count;
  logic       in_valid3 = 1'b0, out_ready3 = 1'b1, cnt_clr3 = 1'b0;
  logic [3:0] in_a3 = '0, in_b3 = '0;
  logic       in_ready3, out_valid3, out_borrow3, out_zero3, rcs_cout3;
  logic [3:0] rcs_a3, rcs_b3, rcs_s3, out_diff3;
  logic [1:0] op_count3, borrow_count3;
  logic [5:0] q[$];
  logic [5:0] q3[$];
  always #5 clk = ~clk;
  assign {rcs_cout, rcs_s}   = {1'b0, rcs_a} + {1'b0, ~rcs_b} + 5'd1;
  assign {rcs_cout3, rcs_s3} = {1'b0, rcs_a3} + {1'b0, ~rcs_b3} + 5'd1;
  rcs_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .rcs_a(rcs_a), .rcs_b(rcs_b), .rcs_s(rcs_s), .rcs_cout(rcs_cout), .out_valid(out_valid),
    .out_ready(out_ready), .out_diff(out_diff), .out_borrow(out_borrow), .out_zero(out_zero),
    .cnt_clr(cnt_clr), .op_count(op_count), .borrow_count(borrow_count)
  );
  rcs_op_sequencer #(.SETTLE_CYCLES(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .in_a(in_a3), .in_b(in_b3),
    .rcs_a(rcs_a3), .rcs_b(rcs_b3), .rcs_s(rcs_s3), .rcs_cout(rcs_cout3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_diff(out_diff3), .out_borrow(out_borrow3), .out_zero(out_zero3),
    .cnt_clr(cnt_clr3), .op_count(op_count3), .borrow_count(borrow_count3)
  );
  function automatic logic [5:0] expect_of(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] d;
    d = a - b;
    return {d, a < b, d == 4'd0};
  endfunction
  task automatic accept_op(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    q.push_back(expect_of(a, b));
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin tests++; fails++; $display("FAIL accept_timeout in_ready=%b wanted 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic wait_res(output int lat, output logic [5:0] e);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 50);
    e = q.size() > 0 ? q.pop_front() : 6'h3f;
    if (!out_valid) begin tests++; fails++; $display("FAIL result_timeout out_valid=%b wanted 1", out_valid); end
  endtask
  task automatic run3(input logic [3:0] a, input logic [3:0] b, output int lat, output logic [5:0] e);
    in_valid3 = 1'b1; in_a3 = a; in_b3 = b;
    q3.push_back(expect_of(a, b));
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid3 && lat < 50);
    e = q3.size() > 0 ? q3.pop_front() : 6'h3f;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tests++;
    if ({rcs_a, rcs_b, out_diff, out_borrow, out_zero, out_valid} !== 15'd0) begin
      fails++; $display("FAIL reset_outputs got %h wanted 0", {rcs_a, rcs_b, out_diff, out_borrow, out_zero, out_valid});
    end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b wanted 1", in_ready); end
    tests++;
    if ({op_count, borrow_count} !== 16'd0) begin fails++; $display("FAIL reset_counters got %h wanted 0", {op_count, borrow_count}); end
    repeat (3) begin
      @(posedge clk); #1;
      tests++;
      if ({rcs_a, rcs_b, out_valid} !== 9'd0) begin fails++; $display("FAIL idle_stable got %h wanted 0", {rcs_a, rcs_b, out_valid}); end
    end
  endtask
  task automatic test_basic();
    logic [3:0] va [3] = '{4'h5, 4'h9, 4'hF};
    logic [3:0] vb [3] = '{4'h3, 4'h6, 4'h1};
    logic [3:0] vd [3] = '{4'h2, 4'h3, 4'hE};
    logic [5:0] e;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      accept_op(va[i], vb[i]);
      wait_res(lat, e);
      tests++;
      if (lat != 1) begin fails++; $display("FAIL basic_latency[%0d] got %0d wanted 1", i, lat); end
      tests++;
      if ({out_diff, out_borrow, out_zero} !== e || out_diff !== vd[i]) begin
        fails++; $display("FAIL basic_result[%0d] got %h wanted %h", i, {out_diff, out_borrow, out_zero}, e);
      end
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drop[%0d] out_valid=%b wanted 0", i, out_valid); end
    end
  endtask
  task automatic test_zero_borrow();
    logic [5:0] e;
    int lat;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    accept_op(4'hF, 4'hF);
    wait_res(lat, e);
    tests++;
    if ({out_diff, out_borrow, out_zero} !== e || out_zero !== 1'b1) begin
      fails++; $display("FAIL zero_result got %h wanted %h", {out_diff, out_borrow, out_zero}, e);
    end
    @(posedge clk); #1;
    accept_op(4'h0, 4'h1);
    wait_res(lat, e);
    tests++;
    if ({out_diff, out_borrow, out_zero} !== e || out_borrow !== 1'b1) begin
      fails++; $display("FAIL borrow_result got %h wanted %h", {out_diff, out_borrow, out_zero}, e);
    end
    @(posedge clk); #1;
    tests++;
    if (op_count !== 8'd2 || borrow_count !== 8'd1) begin
      fails++; $display("FAIL zb_counters got op=%0d brw=%0d wanted op=2 brw=1", op_count, borrow_count);
    end
  endtask
  task automatic test_backpressure();
    logic [5:0] e;
    int lat;
    out_ready = 1'b0;
    accept_op(4'h5, 4'h3);
    wait_res(lat, e);
    tests++;
    if ({out_diff, out_borrow, out_zero} !== e) begin fails++; $display("FAIL bp_first got %h wanted %h", {out_diff, out_borrow, out_zero}, e); end
    in_valid = 1'b1; in_a = 4'h9; in_b = 4'h6;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || out_diff !== 4'h2 || in_ready !== 1'b0 || rcs_a !== 4'h5) begin
        fails++; $display("FAIL bp_hold[%0d] got v=%b d=%h rdy=%b a=%h wanted v=1 d=2 rdy=0 a=5", i, out_valid, out_diff, in_ready, rcs_a);
      end
    end
    q.push_back(expect_of(4'h9, 4'h6));
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || rcs_a !== 4'h9 || rcs_b !== 4'h6) begin
      fails++; $display("FAIL bp_same_edge got v=%b a=%h b=%h wanted v=0 a=9 b=6", out_valid, rcs_a, rcs_b);
    end
    wait_res(lat, e);
    tests++;
    if (lat != 1 || {out_diff, out_borrow, out_zero} !== e) begin
      fails++; $display("FAIL bp_second got lat=%0d r=%h wanted lat=1 r=%h", lat, {out_diff, out_borrow, out_zero}, e);
    end
    @(posedge clk); #1;
    tests++;
    if (op_count !== 8'd4 || borrow_count !== 8'd1) begin
      fails++; $display("FAIL bp_counters got op=%0d brw=%0d wanted op=4 brw=1", op_count, borrow_count);
    end
  endtask
  task automatic test_settle3();
    logic [5:0] e;
    in_valid3 = 1'b1; in_a3 = 4'hC; in_b3 = 4'h5;
    q3.push_back(expect_of(4'hC, 4'h5));
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      tests++;
      if (rcs_a3 !== 4'hC || rcs_b3 !== 4'h5 || out_valid3 !== (k == 3)) begin
        fails++; $display("FAIL settle3_edge%0d got a=%h b=%h v=%b wanted a=c b=5 v=%b", k, rcs_a3, rcs_b3, out_valid3, k == 3);
      end
    end
    e = q3.pop_front();
    tests++;
    if ({out_diff3, out_borrow3, out_zero3} !== e) begin fails++; $display("FAIL settle3_result got %h wanted %h", {out_diff3, out_borrow3, out_zero3}, e); end
    @(posedge clk); #1;
    tests++;
    if (op_count3 !== 2'd1 || out_valid3 !== 1'b0) begin fails++; $display("FAIL settle3_count got op=%0d v=%b wanted op=1 v=0", op_count3, out_valid3); end
  endtask
  task automatic test_saturation();
    logic [5:0] e;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run3(4'(i), 4'(i + 4), lat, e);
      tests++;
      if (lat != 3 || {out_diff3, out_borrow3, out_zero3} !== e) begin
        fails++; $display("FAIL sat_result[%0d] got lat=%0d r=%h wanted lat=3 r=%h", i, lat, {out_diff3, out_borrow3, out_zero3}, e);
      end
      @(posedge clk); #1;
      tests++;
      if (op_count3 !== 2'((i + 2 > 3) ? 3 : i + 2) || borrow_count3 !== 2'((i + 1 > 3) ? 3 : i + 1)) begin
        fails++; $display("FAIL sat_count[%0d] got op=%0d brw=%0d wanted op=%0d brw=%0d", i, op_count3, borrow_count3,
                          (i + 2 > 3) ? 3 : i + 2, (i + 1 > 3) ? 3 : i + 1);
      end
    end
  endtask
  task automatic test_reset_mid();
    out_ready = 1'b1;
    accept_op(4'h6, 4'h1);
    rst_n = 1'b0;
    #1;
    q.delete();
    tests++;
    if (rcs_a !== 4'h0 || rcs_b !== 4'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL rstmid_async got a=%h b=%h v=%b rdy=%b wanted 0 0 0 1", rcs_a, rcs_b, out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0 || op_count !== 8'd0 || borrow_count !== 8'd0) begin
        fails++; $display("FAIL rstmid_quiet[%0d] got v=%b op=%0d brw=%0d wanted 0 0 0", i, out_valid, op_count, borrow_count);
      end
    end
  endtask
  task automatic test_cnt_clr();
    logic [5:0] e;
    int lat;
    out_ready = 1'b1;
    accept_op(4'h2, 4'h7);
    wait_res(lat, e);
    @(posedge clk); #1;
    tests++;
    if (op_count !== 8'd1 || borrow_count !== 8'd1) begin fails++; $display("FAIL clr_pre got op=%0d brw=%0d wanted 1 1", op_count, borrow_count); end
    out_ready = 1'b0;
    accept_op(4'h3, 4'h8);
    wait_res(lat, e);
    tests++;
    if ({out_diff, out_borrow, out_zero} !== e) begin fails++; $display("FAIL clr_result got %h wanted %h", {out_diff, out_borrow, out_zero}, e); end
    cnt_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    tests++;
    if (op_count !== 8'd0 || borrow_count !== 8'd0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL clr_wins got op=%0d brw=%0d v=%b wanted 0 0 0", op_count, borrow_count, out_valid);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_zero_borrow();
    test_backpressure();
    test_settle3();
    test_saturation();
    test_reset_mid();
    test_cnt_clr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
